tile_ram_arbiter: RTL and testbench
===================================

// Module: tile_ram_arbiter
// PURPOSE
//  Owns the single-port 32-bit tile-state RAM (26x16 tiles, 24px each) and shares it between the VGA
//  sprite renderer (read-only, top priority) and the game-logic engine (read/write, req/gnt handshake).
//  Game accesses are granted only while the beam is below the playfield, so renderer reads never stall.
//  Also sequences the 3-step sprite animation_count from vsync edges; sits between renderer, game FSM, RAM.
// PARAMETERS
//  TILES_X          26   tiles per row; RAM address = tile_y*TILES_X + tile_x
//  TILES_Y          16   tile rows; valid addresses 0..TILES_X*TILES_Y-1 (0..415)
//  PLAY_H           384  first DrawY outside the playfield (TILES_Y*24)
//  LAST_LINE        524  last DrawY of the frame (800x525 timing)
//  FRAMES_PER_STEP  12   vsync rising edges per animation step
// PORTS
//  vga_clk          in   1   pixel clock; all logic on posedge
//  reset_n          in   1   synchronous, active-low reset
//  DrawY            in   10  current beam line from the VGA controller
//  vsync            in   1   VGA vsync (active-low pulse); edge-detected internally
//  anim_freeze      in   1   1 = hold animation_count (pause screen)
//  rnd_addr         in   10  renderer tile address (combinational from DrawX/DrawY)
//  rnd_data         out  32  RAM read data to renderer (1-cycle RAM latency)
//  animation_count  out  2   sprite animation step: 0,1,2
//  frame_pulse      out  1   1-cycle pulse on each vsync falling edge (frame start for game logic)
//  g_req            in   1   game request; hold g_we/g_addr/g_wdata stable until g_gnt
//  g_we             in   1   1 = write, 0 = read
//  g_addr           in   10  game tile address
//  g_wdata          in   32  game write data
//  g_gnt            out  1   1-cycle pulse: access issued to RAM this cycle
//  g_rvalid         out  1   1-cycle pulse, cycle after a read grant; g_rdata valid
//  g_rdata          out  32  read data (held until next read)
//  g_err            out  1   1-cycle pulse with g_gnt when g_addr out of range
//  ram_addr         out  10  RAM address
//  ram_we           out  1   RAM write enable
//  ram_wdata        out  32  RAM write data
//  ram_rdata        in   32  RAM read data, valid 1 cycle after address
// BEHAVIOUR
//  Reset (reset_n=0 on a posedge): FSM->RENDER; g_gnt, g_rvalid, g_err, ram_we, frame_pulse = 0;
//   g_rdata = 0; animation_count = 0; frame counter = 0; vsync edge register = 1. Mid-access reset aborts it (no write).
//  Window: win = (DrawY >= PLAY_H) && (DrawY <= LAST_LINE-1); last line excluded so any access finishes before line 0.
//  FSM states: RENDER, IDLE, ACCESS, READBACK.
//   RENDER: ram_addr=rnd_addr, ram_we=0. -> IDLE when win.
//   IDLE:   ram_addr=rnd_addr. If !win -> RENDER; else if g_req -> ACCESS.
//   ACCESS: ram_addr=g_addr, ram_we=g_we & in_range, g_gnt=1, g_err=!in_range.
//           -> READBACK if !g_we, else IDLE (or RENDER if !win).
//   READBACK: g_rvalid=1, g_rdata = in_range ? ram_rdata : 0; -> IDLE/RENDER by win.
//  Latency: g_req seen in IDLE -> g_gnt next cycle; read data at gnt+1. Min 2 cycles/write, 3/read.
//  g_req while !win: no grant, waits; g_req and win closing same cycle: no grant.
//  Back-to-back: requester may change request the cycle after g_gnt; no burst, at most one access per 2 cycles.
//  rnd_data = ram_rdata always (renderer ignores it outside the playfield); output registered in RAM, not here.
//  Animation: vsync falling edge -> frame_pulse; if !anim_freeze, counter++; when counter hits FRAMES_PER_STEP-1
//   it wraps to 0 and animation_count steps 0->1->2->0 (never 3). Freeze holds counter and step; frame_pulse still fires.
//  Widths: address compare in 10 bits against TILES_X*TILES_Y; counter width $clog2(FRAMES_PER_STEP).
// STRUCTURE
//  tile_state_pkg: TILE_PX=24, TILES_X, TILES_Y, PLAY_W=624, PLAY_H, typedef arb_state_e,
//   typedef struct packed tile_word_t {sprite2[10:0], sprite1[10:0], flags[9:0]}.
//  Sub-module anim_sequencer (vsync edge detect, frame counter, animation_count, frame_pulse).
// TESTING
//  1 Reset: reset_n=0 for 2 cycles mid-ACCESS write -> ram_we=0, outputs 0, animation_count=0.
//  2 g_req write addr 5 data 32'hDEAD_BEEF at DrawY=100 -> no g_gnt until DrawY=384; then 1 gnt, ram_we=1 one cycle.
//  3 Read addr 5 at DrawY=400 -> g_gnt, next cycle g_rvalid=1, g_rdata=32'hDEAD_BEEF.
//  4 g_addr=416 write -> g_gnt+g_err together, ram_we=0; read 416 -> g_rdata=0.
//  5 g_req asserted at DrawY=524 -> no grant; granted at first cycle of DrawY=384 next frame; renderer addrs untouched for DrawY<384.
//  6 36 vsync edges -> animation_count 0->1 at 12th, 2 at 24th, 0 at 36th; anim_freeze=1 holds value, frame_pulse continues.

Source files
------------

// File: rtl/tile_state_pkg.sv
// Shared geometry, arbiter state encoding and tile-word layout for the tile-state RAM.
// Geometry is derived from the tile size so renderer and game logic agree on the playfield extent.
package tile_state_pkg;

    localparam int TILE_PX         = 24;
    localparam int TILES_X         = 26;
    localparam int TILES_Y         = 16;
    localparam int PLAY_W          = TILES_X * TILE_PX;
    localparam int PLAY_H          = TILES_Y * TILE_PX;
    localparam int LAST_LINE       = 524;
    localparam int FRAMES_PER_STEP = 12;
    localparam int NUM_TILES       = TILES_X * TILES_Y;
    localparam int ADDR_W          = 10;
    localparam int DATA_W          = 32;
    localparam int LINE_W          = 10;
    localparam int ANIM_STEPS      = 3;

    typedef enum logic [1:0] {
        ST_RENDER   = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACCESS   = 2'd2,
        ST_READBACK = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [10:0] sprite2;
        logic [10:0] sprite1;
        logic [9:0]  flags;
    } tile_word_t;

    // Animation runs 0,1,2 and wraps; value 3 is never produced.
    function automatic logic [1:0] next_anim_step(input logic [1:0] step);
        logic [1:0] nxt;
        if (step >= 2'(ANIM_STEPS - 1)) begin
            nxt = 2'd0;
        end else begin
            nxt = step + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/anim_sequencer.sv
// Frame-rate sprite animation: detects vsync falling edges, emits a frame pulse,
// and advances the 3-step animation counter once every FRAMES_PER_STEP unfrozen frames.
module anim_sequencer
    import tile_state_pkg::*;
#(
    parameter int FRAMES_PER_STEP_P = FRAMES_PER_STEP
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vsync_i,
    input  logic       anim_freeze_i,
    output logic [1:0] animation_count_o,
    output logic       frame_pulse_o
);

    localparam int CNT_W = $clog2(FRAMES_PER_STEP_P);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP_P - 1);

    logic             vsync_q;
    logic             vsync_fall;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] frame_cnt_d;
    logic [1:0]       step_q;
    logic [1:0]       step_d;
    logic             pulse_q;

    // vsync is an active-low pulse; its leading (falling) edge marks a new frame.
    assign vsync_fall = vsync_q & ~vsync_i;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        step_d      = step_q;
        if (vsync_fall && !anim_freeze_i) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                step_d      = next_anim_step(step_q);
            end else begin
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            vsync_q     <= 1'b1;
            frame_cnt_q <= '0;
            step_q      <= 2'd0;
            pulse_q     <= 1'b0;
        end else begin
            vsync_q     <= vsync_i;
            frame_cnt_q <= frame_cnt_d;
            step_q      <= step_d;
            pulse_q     <= vsync_fall;
        end
    end

    assign animation_count_o = step_q;
    assign frame_pulse_o     = pulse_q;

endmodule

// File: rtl/tile_ram_arbiter.sv
// Shares the single-port tile-state RAM between the renderer (always wins inside the playfield)
// and the game engine, whose accesses are only issued while the beam is below the playfield.
module tile_ram_arbiter
    import tile_state_pkg::*;
#(
    parameter int TILES_X_P         = TILES_X,
    parameter int TILES_Y_P         = TILES_Y,
    parameter int PLAY_H_P          = PLAY_H,
    parameter int LAST_LINE_P       = LAST_LINE,
    parameter int FRAMES_PER_STEP_P = FRAMES_PER_STEP
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [9:0]  DrawY,
    input  logic        vsync,
    input  logic        anim_freeze,
    input  logic [9:0]  rnd_addr,
    output logic [31:0] rnd_data,
    output logic [1:0]  animation_count,
    output logic        frame_pulse,
    input  logic        g_req,
    input  logic        g_we,
    input  logic [9:0]  g_addr,
    input  logic [31:0] g_wdata,
    output logic        g_gnt,
    output logic        g_rvalid,
    output logic [31:0] g_rdata,
    output logic        g_err,
    output logic [9:0]  ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] NUM_TILES_L = ADDR_W'(TILES_X_P * TILES_Y_P);
    localparam logic [LINE_W-1:0] WIN_FIRST   = LINE_W'(PLAY_H_P);
    localparam logic [LINE_W-1:0] WIN_LAST    = LINE_W'(LAST_LINE_P - 1);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       win;
    logic       in_range;
    logic       rd_ok_q;
    tile_word_t rdata_q;

    // The final line is excluded so a read started late still completes before line 0.
    assign win      = (DrawY >= WIN_FIRST) && (DrawY <= WIN_LAST);
    assign in_range = (g_addr < NUM_TILES_L);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q <= ST_RENDER;
            rd_ok_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ACCESS) begin
                rd_ok_q <= in_range;
            end
            if (state_q == ST_READBACK) begin
                rdata_q <= rd_ok_q ? tile_word_t'(ram_rdata) : '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RENDER: begin
                if (win) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!win) begin
                    state_d = ST_RENDER;
                end else if (g_req) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!g_we) begin
                    state_d = ST_READBACK;
                end else begin
                    state_d = win ? ST_IDLE : ST_RENDER;
                end
            end
            ST_READBACK: begin
                state_d = win ? ST_IDLE : ST_RENDER;
            end
            default: state_d = ST_RENDER;
        endcase
    end

    // Strobes are qualified with reset_n so an access interrupted by reset never reaches the RAM.
    always_comb begin
        ram_addr = rnd_addr;
        ram_we   = 1'b0;
        g_gnt    = 1'b0;
        g_err    = 1'b0;
        g_rvalid = 1'b0;
        g_rdata  = rdata_q;
        unique case (state_q)
            ST_ACCESS: begin
                ram_addr = g_addr;
                ram_we   = g_we & in_range & reset_n;
                g_gnt    = reset_n;
                g_err    = ~in_range & reset_n;
            end
            ST_READBACK: begin
                g_rvalid = reset_n;
                g_rdata  = rd_ok_q ? ram_rdata : '0;
            end
            default: begin
                ram_addr = rnd_addr;
            end
        endcase
    end

    assign ram_wdata = g_wdata;
    assign rnd_data  = ram_rdata;

    anim_sequencer #(
        .FRAMES_PER_STEP_P(FRAMES_PER_STEP_P)
    ) u_anim (
        .vga_clk          (vga_clk),
        .reset_n          (reset_n),
        .vsync_i          (vsync),
        .anim_freeze_i    (anim_freeze),
        .animation_count_o(animation_count),
        .frame_pulse_o    (frame_pulse)
    );

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Randomised bench for tile_ram_arbiter: behavioural RAM, tile-array reference model and animation model.
module tb_tile_ram_arbiter;

    localparam int NT       = 26 * 16;
    localparam int PH       = 16 * 24;
    localparam int LL       = 524;
    localparam int FPS      = 12;
    localparam int LINE_CYC = 4;

    logic        clk;
    logic        reset_n;
    logic [9:0]  DrawY;
    logic        vsync;
    logic        anim_freeze;
    logic [9:0]  rnd_addr;
    logic [31:0] rnd_data;
    logic [1:0]  animation_count;
    logic        frame_pulse;
    logic        g_req;
    logic        g_we;
    logic [9:0]  g_addr;
    logic [31:0] g_wdata;
    logic        g_gnt;
    logic        g_rvalid;
    logic [31:0] g_rdata;
    logic        g_err;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int tests_run = 0;
    int tests_failed = 0;
    int iso_viol = 0;
    int rnd_viol = 0;
    int gnt_viol = 0;
    int unfrozen_edges = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    tile_ram_arbiter dut (
        .vga_clk        (clk),
        .reset_n        (reset_n),
        .DrawY          (DrawY),
        .vsync          (vsync),
        .anim_freeze    (anim_freeze),
        .rnd_addr       (rnd_addr),
        .rnd_data       (rnd_data),
        .animation_count(animation_count),
        .frame_pulse    (frame_pulse),
        .g_req          (g_req),
        .g_we           (g_we),
        .g_addr         (g_addr),
        .g_wdata        (g_wdata),
        .g_gnt          (g_gnt),
        .g_rvalid       (g_rvalid),
        .g_rdata        (g_rdata),
        .g_err          (g_err),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Compressed beam: each line lasts LINE_CYC clocks; renderer address changes every clock.
    initial begin
        int cyc;
        cyc = 0;
        DrawY = 10'd0;
        rnd_addr = 10'd0;
        forever begin
            @(posedge clk);
            #1;
            rnd_addr = 10'($urandom_range(0, NT - 1));
            cyc++;
            if (cyc == LINE_CYC) begin
                cyc = 0;
                DrawY = (DrawY == 10'(LL)) ? 10'd0 : DrawY + 10'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && (DrawY < 10'(PH))) begin
            if (ram_we || (ram_addr != rnd_addr)) iso_viol++;
        end
        if (rnd_data !== ram_rdata) rnd_viol++;
        if (g_gnt && (DrawY < 10'(PH))) gnt_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic wait_line(input int line);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((DrawY != 10'(line)) && (n < 5000));
        if (DrawY != 10'(line)) check("wait_line_timeout", 32'(DrawY), 32'(line));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"}, 32'(g_gnt), 32'd0);
        check({tag, "_rvalid"}, 32'(g_rvalid), 32'd0);
        check({tag, "_err"}, 32'(g_err), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_frame_pulse"}, 32'(frame_pulse), 32'd0);
        check({tag, "_rdata"}, g_rdata, 32'd0);
        check({tag, "_anim"}, 32'(animation_count), 32'd0);
    endtask

    // One game access: request, wait for the grant, check strobes, then check readback.
    task automatic access(input logic we, input logic [9:0] addr, input logic [31:0] data,
                          output int line);
        logic        in_rng;
        logic [31:0] exp;
        int          n;
        in_rng = (int'(addr) < NT);
        line = -1;
        @(negedge clk);
        g_req = 1'b1;
        g_we = we;
        g_addr = addr;
        g_wdata = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!g_gnt && (n < 3000));
        if (!g_gnt) begin
            check("gnt_timeout", 32'(g_gnt), 32'd1);
            g_req = 1'b0;
            return;
        end
        line = int'(DrawY);
        check($sformatf("%s_%0d_err", we ? "wr" : "rd", addr), 32'(g_err), 32'(!in_rng));
        check($sformatf("%s_%0d_ram_we", we ? "wr" : "rd", addr), 32'(ram_we), 32'(we && in_rng));
        check($sformatf("%s_%0d_ram_addr", we ? "wr" : "rd", addr), 32'(ram_addr), 32'(addr));
        if (we && in_rng) ref_mem[addr] = data;
        g_req = 1'b0;
        @(negedge clk);
        check("post_gnt_ram_we", 32'(ram_we), 32'd0);
        if (!we) begin
            exp = in_rng ? ref_mem[addr] : 32'd0;
            check($sformatf("rd_%0d_rvalid", addr), 32'(g_rvalid), 32'd1);
            check($sformatf("rd_%0d_rdata", addr), g_rdata, exp);
        end else begin
            check($sformatf("wr_%0d_no_rvalid", addr), 32'(g_rvalid), 32'd0);
        end
    endtask

    // One vsync pulse; the animation model counts unfrozen frames and divides.
    task automatic vs_edge(input logic frz);
        @(posedge clk);
        #1;
        anim_freeze = frz;
        vsync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (!frz) unfrozen_edges++;
        check($sformatf("edge_%0d_pulse", unfrozen_edges), 32'(frame_pulse), 32'd1);
        check($sformatf("edge_%0d_anim", unfrozen_edges), 32'(animation_count),
              32'((unfrozen_edges / FPS) % 3));
        @(posedge clk);
        #1;
        vsync = 1'b1;
        @(negedge clk);
        check("pulse_single", 32'(frame_pulse), 32'd0);
    endtask

    initial begin
        int line;
        int n;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        reset_n = 1'b0;
        g_req = 1'b0;
        g_we = 1'b0;
        g_addr = 10'd0;
        g_wdata = 32'd0;
        vsync = 1'b1;
        anim_freeze = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // Reset arriving during a write grant must suppress the write.
        wait_line(400);
        @(negedge clk);
        g_req = 1'b1;
        g_we = 1'b1;
        g_addr = 10'd9;
        g_wdata = 32'h1234_5678;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!g_gnt && (n < 3000));
        check("rst_setup_gnt", 32'(g_gnt), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_abort_ram_we", 32'(ram_we), 32'd0);
        check("rst_abort_gnt", 32'(g_gnt), 32'd0);
        g_req = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst_mid");
        reset_n = 1'b1;
        access(1'b0, 10'd9, 32'd0, line);

        // Write requested inside the playfield waits for line PH.
        wait_line(100);
        access(1'b1, 10'd5, 32'hDEAD_BEEF, line);
        check("wr5_gnt_line", 32'(line), 32'(PH));

        wait_line(400);
        access(1'b0, 10'd5, 32'd0, line);
        check("rd5_deadbeef", g_rdata, 32'hDEAD_BEEF);

        access(1'b1, 10'd416, 32'hA5A5_5A5A, line);
        access(1'b0, 10'd416, 32'd0, line);
        access(1'b0, 10'd415, 32'd0, line);

        // Request on the excluded last line is served on line PH of the next frame.
        wait_line(LL);
        access(1'b0, 10'd5, 32'd0, line);
        check("last_line_gnt_line", 32'(line), 32'(PH));

        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            access(1'($urandom_range(0, 1)), 10'($urandom_range(0, 439)), $urandom, line);
        end

        for (int e = 0; e < 36; e++) vs_edge(1'b0);
        check("anim_after_36", 32'(animation_count), 32'd0);
        for (int e = 0; e < 10; e++) vs_edge(1'b1);
        for (int e = 0; e < 40; e++) vs_edge(1'($urandom_range(0, 2) == 0));

        check("render_isolation", 32'(iso_viol), 32'd0);
        check("rnd_data_passthru", 32'(rnd_viol), 32'd0);
        check("gnt_in_window", 32'(gnt_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
